// File: rtl/led_seq_pkg.sv
// Shared types, default timing constants and width helpers for the status-LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_HB  = 2'd0,
    ST_ON  = 2'd1,
    ST_OFF = 2'd2,
    ST_GAP = 2'd3
  } state_t;

  localparam int DEF_CLK_DIV   = 25;
  localparam int DEF_ON_TICKS  = 4;
  localparam int DEF_OFF_TICKS = 4;
  localparam int DEF_GAP_TICKS = 16;
  localparam int DEF_HB_TICKS  = 8;
  localparam int DEF_CODE_W    = 4;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock prescaler producing a one-cycle tick strobe every CLK_DIV clocks.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_code_seq.sv
// Status-LED sequencer: heartbeat for code 0, otherwise N blinks followed by a gap, repeated.
// state | meaning
// HB    | heartbeat, LED toggles every HB_TICKS ticks
// ON    | blink lit for ON_TICKS ticks
// OFF   | dark between blinks for OFF_TICKS ticks
// GAP   | dark after the last blink for GAP_TICKS ticks
module led_code_seq
  import led_seq_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int HB_TICKS  = DEF_HB_TICKS,
  parameter int CODE_W    = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  output logic              led,
  output logic              busy
);

  localparam int TW = clog2(max4(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_TICKS));
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] HB_LAST  = TW'(HB_TICKS - 1);

  logic tick;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  state_t            state, state_n;
  logic [TW-1:0]     tick_cnt, tick_cnt_n;
  logic [CODE_W-1:0] blink_cnt, blink_n;
  logic [CODE_W-1:0] cur_code, cur_n;
  logic [CODE_W-1:0] pend_code, pend_code_n;
  logic [CODE_W-1:0] load_code;
  logic              pend_vld, pend_vld_n;
  logic              ready_n, led_n, busy_n;
  logic              accept, consume;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_HB;
      tick_cnt   <= '0;
      blink_cnt  <= '0;
      cur_code   <= '0;
      pend_code  <= '0;
      pend_vld   <= 1'b0;
      code_ready <= 1'b1;
      led        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_cnt_n;
      blink_cnt  <= blink_n;
      cur_code   <= cur_n;
      pend_code  <= pend_code_n;
      pend_vld   <= pend_vld_n;
      code_ready <= ready_n;
      led        <= led_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    blink_n    = blink_cnt;
    cur_n      = cur_code;
    led_n      = led;
    consume    = 1'b0;
    load_code  = '0;
    accept     = code_valid && code_ready;

    if (tick) begin
      case (state)
        ST_HB: begin
          if (tick_cnt == HB_LAST) begin
            tick_cnt_n = '0;
            led_n      = !led;
            // Half-period end is a boundary: a pending code takes over here.
            if (pend_vld) begin
              consume = 1'b1;
              cur_n   = pend_code;
              if (pend_code != '0) begin
                state_n = ST_ON;
                led_n   = 1'b1;
                blink_n = pend_code;
              end
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        ST_ON: begin
          if (tick_cnt == ON_LAST) begin
            tick_cnt_n = '0;
            led_n      = 1'b0;
            blink_n    = blink_cnt - CODE_W'(1);
            state_n    = (blink_cnt == CODE_W'(1)) ? ST_GAP : ST_OFF;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        ST_OFF: begin
          if (tick_cnt == OFF_LAST) begin
            tick_cnt_n = '0;
            led_n      = 1'b1;
            state_n    = ST_ON;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (tick_cnt == GAP_LAST) begin
            tick_cnt_n = '0;
            load_code  = pend_vld ? pend_code : cur_code;
            if (pend_vld) begin
              consume = 1'b1;
              cur_n   = pend_code;
            end
            if (load_code == '0) begin
              state_n = ST_HB;
              led_n   = 1'b0;
            end else begin
              state_n = ST_ON;
              led_n   = 1'b1;
              blink_n = load_code;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        default: begin
          state_n    = ST_HB;
          tick_cnt_n = '0;
          led_n      = 1'b0;
        end
      endcase
    end

    pend_vld_n  = (pend_vld && !consume) || accept;
    pend_code_n = accept ? code : pend_code;
    ready_n     = !pend_vld_n;
    busy_n      = (state_n != ST_HB);
  end

endmodule
